// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: serialises one READ (0x01) or WRITE (0x02) frame per
// request to the board's SPI command target and returns the read response byte.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | cmd_ready high, waiting for a request
// ST_SETUP | select low, first bit on spi_mosi, CLK_DIV cycles
// ST_SHIFT | spi_clk toggles every CLK_DIV cycles for N rising edges
// ST_HOLD  | clock low, select still low, CLK_DIV cycles
// ST_GAP   | select high for SS_IDLE cycles; read response posted on entry

module spi_cmd_master #(
   parameter int CLK_DIV = 4,
   parameter int SS_IDLE = 4
) (
   input  logic       input_clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [3:0] cmd_addr,
   input  logic       cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       spi_clk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_ss
);

   localparam int CNT_MAX = (CLK_DIV > SS_IDLE) ? CLK_DIV : SS_IDLE;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] DIV_LOAD  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] IDLE_LOAD = CW'(SS_IDLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [23:0]     frame;
   logic [23:0]     req_frame;
   logic [4:0]      bit_idx;
   logic            is_read;
   logic [7:0]      rx;
   logic            ready_q;

   // ready_q is registered; gating with reset gives cmd_ready=0 during reset
   // and 1 on the very first cycle after it drops.
   assign cmd_ready = ready_q & ~reset;

   assign req_frame = cmd_write ? {8'h02, 3'b000, cmd_addr, cmd_wdata, 8'h00}
                                : {8'h01, 4'b0000, cmd_addr, 8'h00};

   always_ff @(posedge input_clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         frame     <= '0;
         bit_idx   <= '0;
         is_read   <= 1'b0;
         rx        <= '0;
         ready_q   <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         busy      <= 1'b0;
         spi_clk   <= 1'b0;
         spi_mosi  <= 1'b0;
         spi_ss    <= 1'b1;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  frame    <= req_frame;
                  bit_idx  <= cmd_write ? 5'd15 : 5'd23;
                  is_read  <= ~cmd_write;
                  spi_mosi <= req_frame[23];
                  spi_ss   <= 1'b0;
                  ready_q  <= 1'b0;
                  busy     <= 1'b1;
                  cnt      <= DIV_LOAD;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt == '0) begin
                  spi_clk <= 1'b1;
                  cnt     <= DIV_LOAD;
                  state   <= ST_SHIFT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_SHIFT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  cnt <= DIV_LOAD;
                  if (!spi_clk) begin
                     spi_clk <= 1'b1;
                  end else begin
                     // falling edge: sample before the target updates, then advance
                     spi_clk <= 1'b0;
                     if (bit_idx < 5'd8)
                        rx <= {rx[6:0], spi_miso};
                     if (bit_idx == 5'd0) begin
                        spi_mosi <= 1'b0;
                        state    <= ST_HOLD;
                     end else begin
                        bit_idx  <= bit_idx - 5'd1;
                        frame    <= {frame[22:0], 1'b0};
                        spi_mosi <= frame[22];
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  spi_ss <= 1'b1;
                  cnt    <= IDLE_LOAD;
                  state  <= ST_GAP;
                  if (is_read) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= rx;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt == '0) begin
                  ready_q <= 1'b1;
                  busy    <= 1'b0;
                  state   <= ST_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: two instances (CLK_DIV=2/SS_IDLE=3 and CLK_DIV=1/SS_IDLE=1),
// each wired to a behavioural model of the SPI command target.

module tb_spi_cmd_master;

   typedef struct {
      int         bus;
      logic [7:0] data;
   } rsp_t;

   logic       input_clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid [2];
   logic       cmd_ready [2];
   logic       cmd_write [2];
   logic [3:0] cmd_addr  [2];
   logic       cmd_wdata [2];
   logic       rsp_valid [2];
   logic [7:0] rsp_data  [2];
   logic       busy      [2];
   logic       spi_clk   [2];
   logic       spi_mosi  [2];
   logic       spi_ss    [2];

   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   rsp_t exp_q[$];
   rsp_t obs_q[$];

   int          r_timeout, r_rises, r_ss_low, r_toggles, r_rsp_cnt, r_busy;
   int          r_ss_fall, r_ss_rise, r_rsp_cyc, r_ready, r_first_rise;
   logic [23:0] r_mosi;

   always #5 input_clk = ~input_clk;
   always @(posedge input_clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_bus
      localparam int CD = (g == 0) ? 2 : 1;
      localparam int SI = (g == 0) ? 3 : 1;

      logic        miso = 1'b0;
      logic [15:0] treg = (g == 0) ? 16'h0000 : 16'h003C;
      int          tcnt = 0;
      logic [15:0] tsh = 16'h0000;
      logic [7:0]  tresp = 8'h00;

      spi_cmd_master #(.CLK_DIV(CD), .SS_IDLE(SI)) u_dut (
         .input_clk (input_clk),
         .reset     (reset),
         .cmd_valid (cmd_valid[g]),
         .cmd_ready (cmd_ready[g]),
         .cmd_write (cmd_write[g]),
         .cmd_addr  (cmd_addr[g]),
         .cmd_wdata (cmd_wdata[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_data  (rsp_data[g]),
         .busy      (busy[g]),
         .spi_clk   (spi_clk[g]),
         .spi_mosi  (spi_mosi[g]),
         .spi_miso  (miso),
         .spi_ss    (spi_ss[g])
      );

      // target: shifts in on rising edges, decodes after the second byte
      always @(posedge spi_clk[g] or posedge spi_ss[g]) begin
         if (spi_ss[g]) begin
            tcnt <= 0;
         end else begin
            tsh  <= {tsh[14:0], spi_mosi[g]};
            tcnt <= tcnt + 1;
            if (tcnt == 15) begin
               if (tsh[14:7] == 8'h02)
                  treg[tsh[3:0]] <= spi_mosi[g];
               if (tsh[14:7] == 8'h01) begin
                  case ({tsh[2:0], spi_mosi[g]})
                     4'd0:    tresp <= treg[7:0];
                     4'd1:    tresp <= treg[15:8];
                     default: tresp <= 8'h00;
                  endcase
               end
            end
         end
      end

      always @(negedge spi_clk[g] or posedge spi_ss[g]) begin
         if (spi_ss[g])
            miso <= 1'b0;
         else if (tcnt >= 16 && tcnt <= 23)
            miso <= tresp[3'(23 - tcnt)];
      end
   end

   task automatic do_cmd(input int b, input logic wr, input logic [3:0] addr, input logic wd);
      int   t0;
      int   guard;
      logic pclk;
      logic pss;
      r_timeout = 0; r_rises = 0; r_ss_low = 0; r_toggles = 0; r_rsp_cnt = 0; r_busy = 0;
      r_ss_fall = -1; r_ss_rise = -1; r_rsp_cyc = -1; r_ready = -1; r_first_rise = -1;
      r_mosi = '0;
      @(negedge input_clk);
      cmd_write[b] = wr; cmd_addr[b] = addr; cmd_wdata[b] = wd; cmd_valid[b] = 1'b1;
      guard = 0;
      while (cmd_ready[b] !== 1'b1 && guard < 200) begin
         @(negedge input_clk);
         guard++;
      end
      if (guard >= 200) begin
         r_timeout = 1;
         cmd_valid[b] = 1'b0;
         return;
      end
      t0   = cyc + 1;
      pclk = spi_clk[b];
      pss  = spi_ss[b];
      @(negedge input_clk);
      cmd_valid[b] = 1'b0;
      guard = 0;
      while (guard < 400) begin
         if (spi_ss[b] === 1'b0 && pss === 1'b1) r_ss_fall = cyc - t0;
         if (spi_ss[b] === 1'b1 && pss === 1'b0) r_ss_rise = cyc - t0;
         if (spi_ss[b] === 1'b0) r_ss_low++;
         if (spi_clk[b] !== pclk) r_toggles++;
         if (spi_clk[b] === 1'b1 && pclk === 1'b0) begin
            r_mosi = {r_mosi[22:0], spi_mosi[b]};
            r_rises++;
            if (r_rises == 1) r_first_rise = cyc - t0;
         end
         if (busy[b] === 1'b1) r_busy++;
         if (rsp_valid[b] === 1'b1) begin
            r_rsp_cnt++;
            r_rsp_cyc = cyc - t0;
            obs_q.push_back('{b, rsp_data[b]});
         end
         if (cmd_ready[b] === 1'b1) begin
            r_ready = cyc - t0;
            break;
         end
         pclk = spi_clk[b];
         pss  = spi_ss[b];
         guard++;
         @(negedge input_clk);
      end
      if (r_ready < 0) r_timeout = 1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge input_clk);
      for (int b = 0; b < 2; b++) begin
         n_total++;
         if ({spi_ss[b], spi_clk[b], spi_mosi[b], cmd_ready[b], rsp_valid[b], busy[b], rsp_data[b]}
             !== {6'b100000, 8'h00})
            $display("FAIL reset_values bus%0d: got ss/clk/mosi/rdy/vld/busy/data=%b%b%b%b%b%b/%h want 100000/00",
                     b, spi_ss[b], spi_clk[b], spi_mosi[b], cmd_ready[b], rsp_valid[b], busy[b], rsp_data[b]);
         else n_pass++;
      end
      reset = 1'b0;
      #1;
      n_total++;
      if (cmd_ready[0] !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cmd_ready[0]);
      else n_pass++;
   endtask

   task automatic test_write();
      do_cmd(0, 1'b1, 4'd5, 1'b1);
      n_total++;
      if (r_timeout !== 0 || r_mosi[15:0] !== 16'h020B || r_rises !== 16)
         $display("FAIL write_frame: got mosi=%h rises=%0d timeout=%0d want 020b 16 0", r_mosi[15:0], r_rises, r_timeout);
      else n_pass++;
      n_total++;
      if (r_ss_fall !== 0 || r_first_rise !== 2)
         $display("FAIL write_setup: got ss_fall=%0d first_rise=%0d want 0 2", r_ss_fall, r_first_rise);
      else n_pass++;
      n_total++;
      if (r_ss_low !== 66 || r_ss_rise !== 66)
         $display("FAIL write_ss_low: got low=%0d rise=%0d want 66 66", r_ss_low, r_ss_rise);
      else n_pass++;
      n_total++;
      if (r_rsp_cnt !== 0) $display("FAIL write_no_rsp: got %0d rsp_valid want 0", r_rsp_cnt);
      else n_pass++;
      n_total++;
      if (r_ready !== 69 || r_busy !== 69)
         $display("FAIL write_ready_busy: got ready=%0d busy=%0d want 69 69", r_ready, r_busy);
      else n_pass++;
   endtask

   task automatic test_round_trip();
      rsp_t e;
      rsp_t o;
      do_cmd(0, 1'b1, 4'd9, 1'b1);
      n_total++;
      if (r_timeout !== 0 || r_mosi[15:0] !== 16'h0213)
         $display("FAIL rt_write_frame: got %h want 0213", r_mosi[15:0]);
      else n_pass++;
      exp_q.push_back('{0, 8'h02});
      do_cmd(0, 1'b0, 4'd1, 1'b0);
      n_total++;
      if (r_timeout !== 0 || r_rsp_cnt !== 1 || obs_q.size() == 0) begin
         $display("FAIL rt_read_rsp: got rsp_cnt=%0d timeout=%0d want 1 0", r_rsp_cnt, r_timeout);
         obs_q.delete();
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (o.bus !== e.bus || o.data !== e.data)
            $display("FAIL rt_read_data: got bus%0d %h want bus%0d %h", o.bus, o.data, e.bus, e.data);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] addrs [5] = '{4'd15, 4'd13, 4'd10, 4'd8, 4'd9};
      logic       wds   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int         acc_cyc [5];
      int accepts = 0, falls = 0, high_run = 0, gap_bad = 0, per_bad = 0, rsps = 0, guard = 0;
      logic pending = 1'b0;
      logic pss;
      @(negedge input_clk);
      cmd_write[0] = 1'b1; cmd_addr[0] = addrs[0]; cmd_wdata[0] = wds[0]; cmd_valid[0] = 1'b1;
      pss = spi_ss[0];
      while (guard < 2000) begin
         if (spi_ss[0] === 1'b0 && pss === 1'b1) begin
            falls++;
            // SS_IDLE gap plus the cycle in which the next request is accepted
            if (falls > 1 && high_run != 4) gap_bad++;
            high_run = 0;
         end
         if (spi_ss[0] === 1'b1) high_run++;
         if (rsp_valid[0] === 1'b1) rsps++;
         if (cmd_valid[0] && cmd_ready[0] === 1'b1) begin
            acc_cyc[accepts] = cyc;
            accepts++;
            pending = 1'b1;
         end else if (pending) begin
            pending = 1'b0;
            if (accepts < 5) begin
               cmd_addr[0] = addrs[accepts];
               cmd_wdata[0] = wds[accepts];
            end else begin
               cmd_valid[0] = 1'b0;
            end
         end else if (accepts == 5 && !cmd_valid[0] && cmd_ready[0] === 1'b1) begin
            break;
         end
         pss = spi_ss[0];
         guard++;
         @(negedge input_clk);
      end
      cmd_valid[0] = 1'b0;
      n_total++;
      if (accepts !== 5 || falls !== 5 || guard >= 2000)
         $display("FAIL b2b_accepts: got accepts=%0d frames=%0d want 5 5", accepts, falls);
      else n_pass++;
      n_total++;
      if (gap_bad !== 0) $display("FAIL b2b_ss_gap: got %0d gaps not 4 cycles want 0", gap_bad);
      else n_pass++;
      for (int i = 1; i < accepts; i++)
         if (acc_cyc[i] - acc_cyc[i-1] != 70) per_bad++;
      n_total++;
      if (per_bad !== 0 || accepts < 2) $display("FAIL b2b_period: got %0d periods not 70 want 0", per_bad);
      else n_pass++;
      n_total++;
      if (rsps !== 0 || rsp_data[0] !== 8'h02)
         $display("FAIL b2b_rsp_hold: got rsp_cnt=%0d rsp_data=%h want 0 02", rsps, rsp_data[0]);
      else n_pass++;
   endtask

   task automatic test_drop_busy();
      int   falls = 0, busy_miss = 0, guard = 0;
      logic pss;
      @(negedge input_clk);
      cmd_write[0] = 1'b1; cmd_addr[0] = 4'd0; cmd_wdata[0] = 1'b0; cmd_valid[0] = 1'b1;
      pss = spi_ss[0];
      @(negedge input_clk);
      cmd_valid[0] = 1'b0;
      cmd_addr[0] = 4'd14; cmd_wdata[0] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (spi_ss[0] === 1'b0 && pss === 1'b1) falls++;
         cmd_valid[0] = (i % 7 == 3);
         if (cmd_valid[0] && busy[0] !== 1'b1) busy_miss++;
         pss = spi_ss[0];
         @(negedge input_clk);
      end
      cmd_valid[0] = 1'b0;
      while (guard < 100) begin
         if (spi_ss[0] === 1'b0 && pss === 1'b1) falls++;
         pss = spi_ss[0];
         guard++;
         @(negedge input_clk);
      end
      n_total++;
      if (falls !== 1 || busy_miss !== 0)
         $display("FAIL drop_busy: got frames=%0d unbusy_pulses=%0d want 1 0", falls, busy_miss);
      else n_pass++;
   endtask

   task automatic test_read();
      rsp_t e;
      rsp_t o;
      exp_q.push_back('{0, 8'hA5});
      do_cmd(0, 1'b0, 4'd1, 1'b0);
      n_total++;
      if (r_timeout !== 0 || r_mosi !== 24'h010100 || r_rises !== 24)
         $display("FAIL read_frame: got mosi=%h rises=%0d want 010100 24", r_mosi, r_rises);
      else n_pass++;
      n_total++;
      if (r_rsp_cnt !== 1 || r_ss_rise !== 98 || r_rsp_cyc !== 98 || r_ready !== 101)
         $display("FAIL read_timing: got rsp_cnt=%0d ss_rise=%0d rsp_cyc=%0d ready=%0d want 1 98 98 101",
                  r_rsp_cnt, r_ss_rise, r_rsp_cyc, r_ready);
      else n_pass++;
      n_total++;
      if (obs_q.size() == 0) begin
         $display("FAIL read_data: got no response want a5");
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (o.bus !== e.bus || o.data !== e.data)
            $display("FAIL read_data: got bus%0d %h want bus%0d %h", o.bus, o.data, e.bus, e.data);
         else n_pass++;
      end
   endtask

   task automatic test_clkdiv1();
      rsp_t e;
      rsp_t o;
      exp_q.push_back('{1, 8'h3C});
      do_cmd(1, 1'b0, 4'd0, 1'b0);
      n_total++;
      if (r_timeout !== 0 || r_mosi !== 24'h010000)
         $display("FAIL div1_frame: got mosi=%h want 010000", r_mosi);
      else n_pass++;
      n_total++;
      if (r_toggles !== 48 || r_first_rise !== 1)
         $display("FAIL div1_toggle: got toggles=%0d first_rise=%0d want 48 1", r_toggles, r_first_rise);
      else n_pass++;
      n_total++;
      if (r_ss_rise !== 49 || r_rsp_cyc !== 49 || r_ready !== 50)
         $display("FAIL div1_timing: got ss_rise=%0d rsp_cyc=%0d ready=%0d want 49 49 50", r_ss_rise, r_rsp_cyc, r_ready);
      else n_pass++;
      n_total++;
      if (obs_q.size() == 0) begin
         $display("FAIL div1_data: got no response want 3c");
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (o.bus !== e.bus || o.data !== e.data)
            $display("FAIL div1_data: got bus%0d %h want bus%0d %h", o.bus, o.data, e.bus, e.data);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_frame();
      int   rises = 0, guard = 0, rsps = 0, falls = 0;
      logic pclk;
      logic pss;
      @(negedge input_clk);
      cmd_write[0] = 1'b0; cmd_addr[0] = 4'd1; cmd_valid[0] = 1'b1;
      @(negedge input_clk);
      cmd_valid[0] = 1'b0;
      pclk = spi_clk[0];
      while (guard < 200) begin
         if (spi_clk[0] === 1'b1 && pclk === 1'b0) rises++;
         if (rises == 11) break;
         pclk = spi_clk[0];
         guard++;
         @(negedge input_clk);
      end
      reset = 1'b1;
      @(negedge input_clk);
      n_total++;
      if (rises !== 11 || {spi_ss[0], spi_clk[0], spi_mosi[0], rsp_valid[0]} !== 4'b1000)
         $display("FAIL midrst_abort: got rises=%0d ss/clk/mosi/vld=%b%b%b%b want 11 1000",
                  rises, spi_ss[0], spi_clk[0], spi_mosi[0], rsp_valid[0]);
      else n_pass++;
      n_total++;
      if (cmd_ready[0] !== 1'b0 || rsp_data[0] !== 8'h00)
         $display("FAIL midrst_in_reset: got ready=%b rsp_data=%h want 0 00", cmd_ready[0], rsp_data[0]);
      else n_pass++;
      @(negedge input_clk);
      reset = 1'b0;
      #1;
      n_total++;
      if (cmd_ready[0] !== 1'b1) $display("FAIL midrst_ready: got %b want 1", cmd_ready[0]);
      else n_pass++;
      pss = spi_ss[0];
      for (int i = 0; i < 12; i++) begin
         @(negedge input_clk);
         if (rsp_valid[0] === 1'b1) rsps++;
         if (spi_ss[0] === 1'b0 && pss === 1'b1) falls++;
         pss = spi_ss[0];
      end
      n_total++;
      if (rsps !== 0 || falls !== 0) $display("FAIL midrst_quiet: got rsp=%0d frames=%0d want 0 0", rsps, falls);
      else n_pass++;
   endtask

   initial begin
      for (int b = 0; b < 2; b++) begin
         cmd_valid[b] = 1'b0;
         cmd_write[b] = 1'b0;
         cmd_addr[b]  = 4'd0;
         cmd_wdata[b] = 1'b0;
      end
      test_reset();
      test_write();
      test_round_trip();
      test_back_to_back();
      test_drop_busy();
      test_read();
      test_clkdiv1();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish want finish before 2ms");
      $fatal(1, "timeout");
   end

endmodule
